// File: rtl/hazard_response_unit_pkg.sv
// Shared constants for the hazard response unit: FSM state encodings,
// stall request polarity and the width of the internal sequencing counter.
package hazard_response_unit_pkg;

  // FSM state encodings, kept as plain constants for compatibility with older blocks
  localparam logic [1:0] STATE_RUN   = 2'd0;
  localparam logic [1:0] STATE_STALL = 2'd1;
  localparam logic [1:0] STATE_FLUSH = 2'd2;

  // Level on the stall input that requests a stall (the hazard unit drives it active-low)
  localparam logic STALL_ASSERT = 1'b0;

  // Width of the shared stall/flush sequencing counter (covers STALL_MAX up to 15)
  localparam int SEQ_W = 4;

endpackage

// File: rtl/hazard_response_unit_sat_counter.sv
// Saturating event counter: counts up by one on each inc cycle and
// sticks at all-ones instead of wrapping. Synchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic         at_max_s;

  assign at_max_s = &count_r;
  assign count    = count_r;

  // Count qualified events, holding at the maximum once it is reached
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (inc && !at_max_s) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/hazard_response_unit.sv
// Hazard response unit: turns the hazard detection unit's stall and flush
// requests into per-stage pipeline controls with zero latency, bounds stalls
// with a watchdog, and keeps saturating hazard performance counters.
module hazard_response_unit
  import hazard_response_unit_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int STALL_MAX   = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             busy,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [SEQ_W-1:0] FLUSH_RELOAD = SEQ_W'(FLUSH_DEPTH - 1);
  localparam logic [SEQ_W-1:0] STALL_LIMIT  = SEQ_W'(STALL_MAX);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [SEQ_W-1:0] cnt_r;
  logic [SEQ_W-1:0] cnt_nxt_s;
  logic             timeout_r;
  logic             timeout_set_s;
  logic             stall_req_s;
  logic             stall_drv_s;
  logic             flush_acc_s;

  assign stall_req_s = (stall == STALL_ASSERT);

  // Next-state decode; a flush always wins and abandons any stall in progress.
  // cnt in FLUSH holds the squash cycles still to come, so FLUSH is left
  // during the cycle that would bring it to zero.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    timeout_set_s = 1'b0;
    stall_drv_s   = 1'b0;
    flush_acc_s   = 1'b0;
    if (flush) begin
      flush_acc_s = 1'b1;
      if (FLUSH_DEPTH == 1) begin
        state_nxt_s = STATE_RUN;
        cnt_nxt_s   = {SEQ_W{1'b0}};
      end else begin
        state_nxt_s = STATE_FLUSH;
        cnt_nxt_s   = FLUSH_RELOAD;
      end
    end else begin
      case (state_r)
        STATE_RUN: begin
          if (stall_req_s) begin
            stall_drv_s = 1'b1;
            state_nxt_s = STATE_STALL;
            cnt_nxt_s   = {{(SEQ_W-1){1'b0}}, 1'b1};
          end else begin
            state_nxt_s = STATE_RUN;
            cnt_nxt_s   = {SEQ_W{1'b0}};
          end
        end
        STATE_STALL: begin
          if (stall_req_s && (cnt_r < STALL_LIMIT)) begin
            stall_drv_s = 1'b1;
            state_nxt_s = STATE_STALL;
            cnt_nxt_s   = cnt_r + {{(SEQ_W-1){1'b0}}, 1'b1};
          end else if (stall_req_s) begin
            // Watchdog: release the pipeline even though the stall is still requested
            timeout_set_s = 1'b1;
            state_nxt_s   = STATE_RUN;
            cnt_nxt_s     = {SEQ_W{1'b0}};
          end else begin
            state_nxt_s = STATE_RUN;
            cnt_nxt_s   = {SEQ_W{1'b0}};
          end
        end
        STATE_FLUSH: begin
          if (cnt_r <= {{(SEQ_W-1){1'b0}}, 1'b1}) begin
            state_nxt_s = STATE_RUN;
            cnt_nxt_s   = {SEQ_W{1'b0}};
          end else begin
            state_nxt_s = STATE_FLUSH;
            cnt_nxt_s   = cnt_r - {{(SEQ_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_nxt_s = STATE_RUN;
          cnt_nxt_s   = {SEQ_W{1'b0}};
        end
      endcase
    end
  end

  // Control outputs follow the current state and current requests
  assign ifid_flush    = flush_acc_s || (state_r == STATE_FLUSH);
  assign idex_bubble   = ifid_flush || stall_drv_s;
  assign pc_write      = !stall_drv_s;
  assign ifid_write    = !stall_drv_s;
  assign busy          = (state_r != STATE_RUN);
  assign stall_timeout = timeout_r;

  // State, sequencing counter and sticky watchdog flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= STATE_RUN;
      cnt_r     <= {SEQ_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      timeout_r <= timeout_r | timeout_set_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_drv_s),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_acc_s),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_response_unit.sv
// Directed bench for hazard_response_unit. A second instance with 2-bit
// counters shares the inputs so counter saturation is reachable quickly.
// Control bits are compared as {pc_write, ifid_write, ifid_flush, idex_bubble, busy}.
module tb_hazard_response_unit;

  logic clock;
  logic reset;
  logic stall;
  logic flush;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_timeout;
  logic [15:0] stall_cycles, flush_events;

  logic        pc_write2, ifid_write2, ifid_flush2, idex_bubble2, busy2, stall_timeout2;
  logic [1:0]  stall_cycles2, flush_events2;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] C_NORM   = 5'b11000;
  localparam logic [4:0] C_NORM_B = 5'b11001;
  localparam logic [4:0] C_STL_R  = 5'b00010;
  localparam logic [4:0] C_STL_S  = 5'b00011;
  localparam logic [4:0] C_FL_R   = 5'b11110;
  localparam logic [4:0] C_FL_F   = 5'b11111;

  hazard_response_unit #(.FLUSH_DEPTH(2), .STALL_MAX(3), .CNT_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .busy          (busy),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events)
  );

  hazard_response_unit #(.FLUSH_DEPTH(2), .STALL_MAX(3), .CNT_W(2)) dut_sat (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .pc_write      (pc_write2),
    .ifid_write    (ifid_write2),
    .ifid_flush    (ifid_flush2),
    .idex_bubble   (idex_bubble2),
    .busy          (busy2),
    .stall_timeout (stall_timeout2),
    .stall_cycles  (stall_cycles2),
    .flush_events  (flush_events2)
  );

  // Free-running 10-unit clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check this cycle's controls at the falling edge, then advance one cycle
  task automatic ctl(input string tag, input logic [4:0] exp);
    @(negedge clock);
    check(tag, {27'd0, pc_write, ifid_write, ifid_flush, idex_bubble, busy}, {27'd0, exp});
    @(posedge clock);
    #1;
  endtask

  task automatic cnt_chk(input string tag, input int sc, input int fe, input logic to);
    check({tag, "_stall_cycles"}, {16'd0, stall_cycles}, sc);
    check({tag, "_flush_events"}, {16'd0, flush_events}, fe);
    check({tag, "_timeout"}, {31'd0, stall_timeout}, {31'd0, to});
  endtask

  // Linear directed sequence
  initial begin
    reset = 1'b1;
    stall = 1'b1;
    flush = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;

    // 1. reset state
    cnt_chk("reset", 0, 0, 1'b0);
    ctl("reset_ctl", C_NORM);

    // 2. two-cycle load-use stall
    stall = 1'b0;
    ctl("stall_c1", C_STL_R);
    ctl("stall_c2", C_STL_S);
    stall = 1'b1;
    ctl("stall_release", C_NORM_B);
    ctl("stall_run", C_NORM);
    cnt_chk("after_stall", 2, 0, 1'b0);

    // 3. single taken branch squashes two cycles
    flush = 1'b1;
    ctl("flush_c1", C_FL_R);
    flush = 1'b0;
    ctl("flush_c2", C_FL_F);
    ctl("flush_done", C_NORM);
    cnt_chk("after_flush", 2, 1, 1'b0);

    // 4. flush beats a simultaneous stall
    stall = 1'b0;
    flush = 1'b1;
    ctl("both_c1", C_FL_R);
    stall = 1'b1;
    flush = 1'b0;
    ctl("both_c2", C_FL_F);
    ctl("both_done", C_NORM);
    cnt_chk("after_both", 2, 2, 1'b0);

    // 5. stall held past the watchdog limit
    stall = 1'b0;
    ctl("wd_c1", C_STL_R);
    ctl("wd_c2", C_STL_S);
    ctl("wd_c3", C_STL_S);
    ctl("wd_release", C_NORM_B);
    check("wd_timeout_set", {31'd0, stall_timeout}, 32'd1);
    ctl("wd_restall", C_STL_R);
    stall = 1'b1;
    ctl("wd_exit", C_NORM_B);
    ctl("wd_run", C_NORM);
    cnt_chk("after_wd", 6, 2, 1'b1);
    check("sat_stall_cycles", {30'd0, stall_cycles2}, 32'd3);

    // Back-to-back flushes reload the squash window; narrow counters saturate
    flush = 1'b1;
    ctl("rflush_c1", C_FL_R);
    ctl("rflush_c2", C_FL_F);
    ctl("rflush_c3", C_FL_F);
    flush = 1'b0;
    ctl("rflush_tail", C_FL_F);
    ctl("rflush_done", C_NORM);
    cnt_chk("after_rflush", 6, 5, 1'b1);
    check("sat_flush_events", {30'd0, flush_events2}, 32'd3);
    check("sat_timeout", {31'd0, stall_timeout2}, 32'd1);

    // 6. reset during the second flush cycle
    flush = 1'b1;
    ctl("rst_flush_c1", C_FL_R);
    flush = 1'b0;
    reset = 1'b1;
    ctl("rst_flush_c2", C_FL_F);
    reset = 1'b0;
    cnt_chk("after_reset", 0, 0, 1'b0);
    check("sat_after_reset", {28'd0, stall_cycles2, flush_events2}, 32'd0);
    ctl("rst_run", C_NORM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
